// File: rtl/video_source_switcher.sv
// Frame-synchronous N-way VGA source selector with PS/2 key control and a post-switch
// target_off hold. Define VIDEO_SOURCE_SWITCHER_FADE_EN for a crossfade on every commit.
`timescale 1ns/1ps
module video_source_switcher #(
  parameter int N_SRC         = 4,
  parameter int CW            = 4,
  parameter int RESET_SRC     = 0,
  parameter int HOLD_FRAMES   = 2,
  parameter int VS_ACTIVE_LOW = 1,
  parameter int FADE_LOG2     = 3
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       v_sync,
  input  logic                       DE,
  input  logic [7:0]                 keyboard_data,
  input  logic [N_SRC*3*CW-1:0]      rgb_in,
  input  logic [N_SRC-1:0]           target_off_in,
  output logic [CW-1:0]              r_port,
  output logic [CW-1:0]              g_port,
  output logic [CW-1:0]              b_port,
  output logic                       target_off,
  output logic [$clog2(N_SRC)-1:0]   active_src,
  output logic                       pending
);
  localparam int   SW      = $clog2(N_SRC);
  localparam int   PW      = 3*CW;
  localparam int   HW      = (HOLD_FRAMES > 0) ? $clog2(HOLD_FRAMES+1) : 1;
  localparam logic VS_IDLE = (VS_ACTIVE_LOW != 0);

  typedef struct packed {
    logic       vld;
    logic [2:0] idx;
  } key_req_t;

  logic [N_SRC-1:0][PW-1:0] src;
  assign src = rgb_in;

  logic [7:0]    kb_q;
  logic          vs_q;
  logic [SW-1:0] active_q, active_d, pidx_q, pidx_d, act_eff;
  logic          pending_q, pending_d, pend_eff;
  logic [HW-1:0] hold_q, hold_d;
  logic          boundary, commit, fade_busy;
  logic [2:0]    tgt;
  key_req_t      req;
  logic [PW-1:0] rgb_q;
  logic          toff_q;

  assign boundary = VS_IDLE ? (vs_q & ~v_sync) : (~vs_q & v_sync);
  assign commit   = boundary & pending_q & ~fade_busy;
  // Key requests are judged against the state after any same-cycle commit.
  assign act_eff  = commit ? pidx_q : active_q;
  assign pend_eff = pending_q & ~commit;
  assign tgt      = 3'(pend_eff ? pidx_q : act_eff);

  always_comb begin
    req = '0;
    case (keyboard_data)
      8'h16:   req = '{vld: 1'b1, idx: 3'd0};
      8'h1E:   req = '{vld: 1'b1, idx: 3'd1};
      8'h26:   req = '{vld: 1'b1, idx: 3'd2};
      8'h25:   req = '{vld: 1'b1, idx: 3'd3};
      8'h2E:   req = '{vld: 1'b1, idx: 3'd4};
      8'h36:   req = '{vld: 1'b1, idx: 3'd5};
      8'h3D:   req = '{vld: 1'b1, idx: 3'd6};
      8'h3E:   req = '{vld: 1'b1, idx: 3'd7};
      8'h0D:   req = '{vld: 1'b1, idx: (tgt == 3'(N_SRC-1)) ? 3'd0 : tgt + 3'd1};
      default: req = '0;
    endcase
    if (keyboard_data == kb_q) req.vld = 1'b0;
  end

  always_comb begin
    active_d  = act_eff;
    pending_d = pend_eff;
    pidx_d    = pidx_q;
    hold_d    = hold_q;
    if (commit)                          hold_d = HW'(HOLD_FRAMES);
    else if (boundary && hold_q != '0)   hold_d = hold_q - HW'(1);
    if (req.vld && ({1'b0, req.idx} < 4'(N_SRC))) begin
      if (req.idx == 3'(act_eff)) begin
        pending_d = 1'b0;
      end else begin
        pending_d = 1'b1;
        pidx_d    = req.idx[SW-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      kb_q      <= '0;
      vs_q      <= VS_IDLE;
      active_q  <= SW'(RESET_SRC);
      pidx_q    <= SW'(RESET_SRC);
      pending_q <= 1'b0;
      hold_q    <= HW'(HOLD_FRAMES);
    end else begin
      kb_q      <= keyboard_data;
      vs_q      <= v_sync;
      active_q  <= active_d;
      pidx_q    <= pidx_d;
      pending_q <= pending_d;
      hold_q    <= hold_d;
    end
  end

`ifdef VIDEO_SOURCE_SWITCHER_FADE_EN
  localparam int MW = CW + FADE_LOG2 + 1;

  logic                 fade_q, fade_s1, toff_s1;
  logic [FADE_LOG2-1:0] fk_q, k_s1;
  logic [SW-1:0]        old_q;
  logic [PW-1:0]        new_s1, old_s1, blend;

  assign fade_busy = fade_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      fade_q <= 1'b0;
      fk_q   <= '0;
      old_q  <= SW'(RESET_SRC);
    end else if (commit) begin
      fade_q <= 1'b1;
      fk_q   <= '0;
      old_q  <= active_q;
    end else if (boundary && fade_q) begin
      if (&fk_q) fade_q <= 1'b0;
      else       fk_q   <= fk_q + FADE_LOG2'(1);
    end
  end

  // Stage 1 captures both sources; stage 2 blends them.
  always_ff @(posedge clk) begin
    if (!reset) begin
      new_s1  <= '0;
      old_s1  <= '0;
      fade_s1 <= 1'b0;
      k_s1    <= '0;
      toff_s1 <= 1'b1;
      rgb_q   <= '0;
      toff_q  <= 1'b1;
    end else begin
      new_s1  <= DE ? src[active_q] : '0;
      old_s1  <= DE ? src[old_q]    : '0;
      fade_s1 <= fade_q;
      k_s1    <= fk_q;
      toff_s1 <= (hold_q != '0) | target_off_in[active_q];
      rgb_q   <= blend;
      toff_q  <= toff_s1;
    end
  end

  for (genvar c = 0; c < 3; c++) begin : g_ch
    logic [MW-1:0] mix;
    assign mix = MW'(old_s1[c*CW +: CW]) * (MW'(1 << FADE_LOG2) - MW'(k_s1))
               + MW'(new_s1[c*CW +: CW]) * MW'(k_s1);
    assign blend[c*CW +: CW] = fade_s1 ? mix[FADE_LOG2 +: CW] : new_s1[c*CW +: CW];
  end
`else
  assign fade_busy = 1'b0;

  always_ff @(posedge clk) begin
    if (!reset) begin
      rgb_q  <= '0;
      toff_q <= 1'b1;
    end else begin
      rgb_q  <= DE ? src[active_q] : '0;
      toff_q <= (hold_q != '0) | target_off_in[active_q];
    end
  end
`endif

  assign r_port     = rgb_q[3*CW-1 -: CW];
  assign g_port     = rgb_q[2*CW-1 -: CW];
  assign b_port     = rgb_q[CW-1:0];
  assign target_off = toff_q;
  assign active_src = active_q;
  assign pending    = pending_q;

endmodule

// File: tb/tb_video_source_switcher.sv
// Randomized + directed bench for video_source_switcher (default build, instantaneous cut).
`timescale 1ns/1ps
module tb_video_source_switcher;
  localparam int N   = 4;
  localparam int CW  = 4;
  localparam int FL  = 32;  // cycles per frame
  localparam int VSL = 3;   // v_sync low cycles at frame start

  logic            clk = 1'b0, reset = 1'b0, v_sync = 1'b1, DE = 1'b0;
  logic [7:0]      kb = 8'h00;
  logic [N*3*CW-1:0] rgb_in = '0;
  logic [N-1:0]    toff_in = '0;
  logic [CW-1:0]   r, g, b;
  logic            toff, pend;
  logic [1:0]      act;

  video_source_switcher #(.N_SRC(N), .CW(CW), .RESET_SRC(0), .HOLD_FRAMES(2),
                          .VS_ACTIVE_LOW(1), .FADE_LOG2(3)) dut (
    .clk(clk), .reset(reset), .v_sync(v_sync), .DE(DE), .keyboard_data(kb),
    .rgb_in(rgb_in), .target_off_in(toff_in), .r_port(r), .g_port(g), .b_port(b),
    .target_off(toff), .active_src(act), .pending(pend));

  always #5 clk = ~clk;

  int checks = 0, failures = 0, fpos = 0;
  int m_act, m_pidx, m_hold;
  bit m_pend, m_vs;
  logic [7:0]  m_kb;
  logic [11:0] e_rgb;
  bit          e_toff;
  logic [7:0]  keymap [8] = '{8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [11:0] pix(input int k);
    return rgb_in[k*12 +: 12];
  endfunction

  // One clock: predict from the rules, advance, then compare every output.
  task automatic step();
    int idx;
    v_sync = (fpos < VSL) ? 1'b0 : 1'b1;
    if (!reset) begin
      e_rgb = '0; e_toff = 1'b1;
      m_act = 0; m_pend = 0; m_pidx = 0; m_hold = 2; m_kb = 8'h00; m_vs = 1'b1;
    end else begin
      e_rgb  = DE ? pix(m_act) : 12'h000;
      e_toff = (m_hold > 0) ? 1'b1 : toff_in[m_act];
      if (m_vs && !v_sync) begin
        if (m_pend) begin
          m_act = m_pidx; m_pend = 0; m_hold = 2;
        end else if (m_hold > 0) m_hold--;
      end
      if (kb != m_kb && kb != 8'h00) begin
        idx = -1;
        for (int i = 0; i < 8; i++) if (keymap[i] == kb) idx = i;
        if (kb == 8'h0D) idx = ((m_pend ? m_pidx : m_act) + 1) % N;
        if (idx >= 0 && idx < N) begin
          if (idx == m_act) m_pend = 0;
          else begin m_pend = 1; m_pidx = idx; end
        end
      end
      m_kb = kb;
      m_vs = v_sync;
    end
    @(posedge clk); #1;
    chk("rgb", 32'({r, g, b}), 32'(e_rgb));
    chk("toff", 32'(toff), 32'(e_toff));
    chk("act", 32'(act), 32'(m_act));
    chk("pend", 32'(pend), 32'(m_pend));
    fpos = (fpos + 1) % FL;
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic to_boundary();
    for (int i = 0; i < FL && fpos != 0; i++) step();
  endtask

  task automatic mid();
    for (int i = 0; i < FL && fpos != FL/2; i++) step();
  endtask

  initial begin
    int sel;
    rgb_in  = {12'h789, 12'h456, 12'h123, 12'hFA5};
    toff_in = 4'b1010;
    run(3);
    chk("rst_act", 32'(act), 32'd0);
    chk("rst_toff", 32'(toff), 32'd1);

    reset = 1'b1; DE = 1'b1;
    step();
    chk("pass", 32'({r, g, b}), 32'h0FA5);
    chk("hold_on", 32'(toff), 32'd1);
    run(2*FL + 2);
    chk("hold_off", 32'(toff), 32'd0);

    mid(); kb = 8'h26; step();
    chk("defer_pend", 32'(pend), 32'd1);
    chk("defer_act", 32'(act), 32'd0);
    to_boundary(); step();
    chk("commit_act", 32'(act), 32'd2);
    chk("commit_pend", 32'(pend), 32'd0);
    step();
    chk("cut_pix", 32'({r, g, b}), 32'h0456);

    mid(); kb = 8'h1E; step(); kb = 8'h25; step();
    to_boundary(); step();
    chk("lastkey", 32'(act), 32'd3);

    mid(); kb = 8'h0D; step();
    to_boundary(); step();
    chk("tabwrap", 32'(act), 32'd0);

    mid(); kb = 8'h1E; step();
    chk("cancel_a", 32'(pend), 32'd1);
    kb = 8'h16; step();
    chk("cancel_b", 32'(pend), 32'd0);
    to_boundary(); step();
    chk("cancel_act", 32'(act), 32'd0);

    kb = 8'h2E; step();
    chk("inval", 32'(pend), 32'd0);
    run(5);
    chk("inval_hold", 32'(pend), 32'd0);

    to_boundary(); kb = 8'h26; step();
    chk("simul_act", 32'(act), 32'd0);
    chk("simul_pend", 32'(pend), 32'd1);
    to_boundary(); step();
    chk("simul_commit", 32'(act), 32'd2);

    DE = 1'b0; step(); step();
    chk("de_off", 32'({r, g, b}), 32'd0);

    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 7) == 0) begin
        sel = $urandom_range(0, 11);
        if (sel < 8)        kb = keymap[sel];
        else if (sel == 8)  kb = 8'h0D;
        else if (sel == 9)  kb = 8'h00;
        else if (sel == 10) kb = 8'($urandom());
      end
      DE      = ($urandom_range(0, 3) != 0);
      rgb_in  = 48'({$urandom(), $urandom()});
      if ($urandom_range(0, 15) == 0) toff_in = 4'($urandom());
      reset   = ($urandom_range(0, 599) != 0);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
